// File: rtl/riscv_branch_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch funct3 codes,
// 2-bit bimodal counter states and the saturating counter update rule.
package riscv_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = BHT_WNT;

    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        logic [1:0] c;
        c = cur;
        if (taken)
            return (cur == BHT_ST) ? BHT_ST : bht_state_e'(c + 2'd1);
        else
            return (cur == BHT_SNT) ? BHT_SNT : bht_state_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Array of 2-bit saturating counters: one combinational read port returning
// the predict bit, one synchronous update port. Reads see the pre-update value.
module bht_counter_table
    import riscv_branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_state_e tbl [ENTRIES];

    assign rd_taken = tbl[rd_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                tbl[i] <= BHT_RESET;
        end else if (upd_en) begin
            tbl[upd_idx] <= bht_next(tbl[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolver: funct3 decode, mispredict redirect, bimodal BHT
// training and branch/mispredict performance counters.
module branch_resolve_bht
    import riscv_branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_LSB     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_stall,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            BrUn,
    input  logic            BrEq,
    input  logic            BrLt,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_br,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic        resolve;
    logic        taken;
    logic        bad_f3;
    logic        update;
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;
    logic        unused_if_pc;

    assign unused_if_pc = ^if_pc;

    assign resolve = ex_valid & ex_is_branch & ~ex_stall;
    assign BrUn    = ex_funct3[1];
    assign bad_f3  = (ex_funct3[2:1] == 2'b01);
    assign update  = resolve & ~bad_f3;

    always_comb begin
        taken = 1'b0;
        case (ex_funct3)
            F3_BEQ:           taken = BrEq;
            F3_BNE:           taken = ~BrEq;
            F3_BLT, F3_BLTU:  taken = BrLt;
            F3_BGE, F3_BGEU:  taken = ~BrLt;
            default:          taken = 1'b0;
        endcase
    end

    // Gated by rst_n so nothing escapes while the core is held in reset.
    assign illegal_br     = rst_n & resolve & bad_f3;
    assign redirect_valid = rst_n & update & (taken != ex_pred_taken);
    assign redirect_pc    = taken ? ex_target : ex_pc + XLEN'(4);

    bht_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_LSB +: IDX_W]),
        .rd_taken  (if_pred_taken),
        .upd_en    (update),
        .upd_idx   (ex_pc[IDX_LSB +: IDX_W]),
        .upd_taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (update)
                br_count_q <= br_count_q + 32'd1;
            if (redirect_valid)
                mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: a stimulus process predicts each
// cycle's outputs from a table-of-integers model; a negedge monitor compares.
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic        ex_stall = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic        BrUn;
    logic        BrEq = 1'b0;
    logic        BrLt = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_resolve_bht #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .IDX_LSB     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_stall       (ex_stall),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .BrUn           (BrUn),
        .BrEq           (BrEq),
        .BrLt           (BrLt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal_br     (illegal_br),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        brun;
        logic        rv;
        logic        ill;
        logic        ifp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: counter strength 0..3 per entry, plain integer counts.
    int          bht [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht[i] = 1;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        bit   t, illf3, res;
        int   i;
        case (ex_funct3)
            3'd0:       t = BrEq;
            3'd1:       t = !BrEq;
            3'd4, 3'd6: t = BrLt;
            3'd5, 3'd7: t = !BrLt;
            default:    t = 0;
        endcase
        illf3  = (ex_funct3 == 3'd2) || (ex_funct3 == 3'd3);
        res    = ex_valid && ex_is_branch && !ex_stall;
        e.brun = (ex_funct3 >= 3'd2 && ex_funct3 <= 3'd3) || ex_funct3 >= 3'd6;
        e.rv   = rst_n && res && !illf3 && (t != ex_pred_taken);
        e.ill  = rst_n && res && illf3;
        e.rpc  = t ? ex_target : ex_pc + 32'd4;
        e.ifp  = bht[idx_of(if_pc)] >= 2;
        e.bc   = m_br;
        e.mc   = m_mis;
        sb.push_back(e);
        if (rst_n && res && !illf3) begin
            i = idx_of(ex_pc);
            if (t) bht[i] = (bht[i] == 3) ? 3 : bht[i] + 1;
            else   bht[i] = (bht[i] == 0) ? 0 : bht[i] - 1;
            m_br = m_br + 1;
            if (e.rv) m_mis = m_mis + 1;
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit s, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                         input bit eq, input bit lt, input logic [31:0] ipc);
        ex_valid      = v;
        ex_is_branch  = b;
        ex_stall      = s;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        BrEq          = eq;
        BrLt          = lt;
        if_pc         = ipc;
    endtask

    task automatic cyc(input bit v, input bit b, input bit s, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                       input bit eq, input bit lt, input logic [31:0] ipc);
        @(posedge clk);
        #1;
        drive(v, b, s, f3, pc, tgt, pred, eq, lt, ipc);
        push_exp();
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, ipc);
    endtask

    // Reset asserted mid-cycle while a mispredicting branch sits in EX.
    task automatic mid_reset(input logic [31:0] pc);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 3'd1, pc, pc + 32'h20, 0, 0, 0, pc);
        #1;
        rst_n = 1'b0;
        model_reset();
        push_exp();
        idle(pc);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("BrUn",           32'(BrUn),           32'(e.brun));
            check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            check("redirect_pc",    redirect_pc,         e.rpc);
            check("illegal_br",     32'(illegal_br),     32'(e.ill));
            check("if_pred_taken",  32'(if_pred_taken),  32'(e.ifp));
            check("br_count",       br_count,            e.bc);
            check("mispred_count",  mispred_count,       e.mc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [6];
        logic [31:0] pc, ipc;
        int          waited;
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0104;
        pool[2] = 32'h0000_0200;
        pool[3] = 32'h0000_0300;
        pool[4] = 32'h0000_0200;
        pool[5] = 32'hFFFF_FFFC;

        model_reset();
        idle(32'h100);
        idle(32'h100);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // BEQ taken, predicted not-taken
        cyc(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 1, 0, 32'h100);
        idle(32'h100);
        // compare-signedness select and BGE mispredict falling through
        cyc(1, 1, 0, 3'd6, 32'h180, 32'h1c0, 0, 0, 0, 32'h180);
        cyc(1, 1, 0, 3'd5, 32'h184, 32'h1c0, 1, 0, 0, 32'h184);
        cyc(1, 1, 0, 3'd5, 32'h200, 32'h280, 1, 0, 1, 32'h200);
        // saturation at strong-taken, then one not-taken
        for (int k = 0; k < 4; k++)
            cyc(1, 1, 0, 3'd4, 32'h300, 32'h340, 1, 0, 1, 32'h300);
        idle(32'h300);
        cyc(1, 1, 0, 3'd4, 32'h300, 32'h340, 1, 0, 0, 32'h300);
        idle(32'h300);
        // reserved funct3 encodings
        cyc(1, 1, 0, 3'd2, 32'h400, 32'h440, 0, 1, 1, 32'h400);
        cyc(1, 1, 0, 3'd3, 32'h400, 32'h440, 1, 0, 0, 32'h400);
        idle(32'h400);
        // stalled mispredict, then released
        cyc(1, 1, 1, 3'd1, 32'h500, 32'h540, 0, 0, 0, 32'h500);
        cyc(1, 1, 0, 3'd1, 32'h500, 32'h540, 0, 0, 0, 32'h500);
        idle(32'h500);
        // fall-through wraps past the top of the address space
        cyc(1, 1, 0, 3'd0, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 32'hFFFF_FFFC);
        mid_reset(32'h100);
        cyc(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 1, 0, 32'h100);
        idle(32'h100);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                mid_reset(pool[$urandom_range(0, 5)]);
            end else begin
                pc  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                  : pool[$urandom_range(0, 5)];
                ipc = ($urandom_range(0, 1) == 0) ? pc : pool[$urandom_range(0, 5)];
                cyc($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
                    pc, $urandom() & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ipc);
            end
        end

        idle(32'h0);
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
